// File: rtl/regfile_pkg.sv
// Shared register-file definitions: architectural index encoding and scoreboard sizing.
package regfile_pkg;

    localparam int unsigned NREGS   = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned INFL_W  = 6;
    localparam int unsigned STALL_W = 32;

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam reg_idx_t REG_RAX = 4'd0;
    localparam reg_idx_t REG_RCX = 4'd1;
    localparam reg_idx_t REG_RDX = 4'd2;
    localparam reg_idx_t REG_RBX = 4'd3;
    localparam reg_idx_t REG_RSP = 4'd4;
    localparam reg_idx_t REG_RBP = 4'd5;
    localparam reg_idx_t REG_RSI = 4'd6;
    localparam reg_idx_t REG_RDI = 4'd7;
    localparam reg_idx_t REG_R8  = 4'd8;
    localparam reg_idx_t REG_R9  = 4'd9;
    localparam reg_idx_t REG_R10 = 4'd10;
    localparam reg_idx_t REG_R11 = 4'd11;
    localparam reg_idx_t REG_R12 = 4'd12;
    localparam reg_idx_t REG_R13 = 4'd13;
    localparam reg_idx_t REG_R14 = 4'd14;
    localparam reg_idx_t REG_R15 = 4'd15;

endpackage

// File: rtl/reg_busy_counter.sv
// In-flight write counter for one architectural register; clear beats inc/dec,
// and a simultaneous inc and dec cancel.
module reg_busy_counter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output cnt_t count,
    output logic busy,
    output logic sat
);

    logic incEff;
    logic decEff;

    assign busy   = (count != '0);
    assign sat    = (count == '1);
    assign incEff = inc && !sat;
    assign decEff = dec && busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (incEff && !decEff) begin
            count <= count + CNT_W'(1);
        end else if (decEff && !incEff) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard: blocks RAW hazards and per-register write saturation,
// retires pending writes on writeback and drops them all on flush.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic              iss_src_a_vld,
    input  reg_idx_t          iss_src_a,
    input  logic              iss_src_b_vld,
    input  reg_idx_t          iss_src_b,
    input  logic              iss_dst_vld,
    input  reg_idx_t          iss_dst,
    input  logic              wb_valid,
    input  reg_idx_t          wb_dst,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_mask,
    output logic [INFL_W-1:0] inflight,
    output logic [STALL_W-1:0] stall_cnt,
    output logic              wb_err
);

    cnt_t             countArr [NREGS];
    logic [NREGS-1:0] busyVec;
    logic [NREGS-1:0] satVec;
    logic [NREGS-1:0] incVec;
    logic [NREGS-1:0] decVec;

    logic hazA;
    logic hazB;
    logic fullD;
    logic fire;
    logic incOne;
    logic decOne;
    logic wbSpurious;

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        assign incVec[r] = fire && iss_dst_vld && (iss_dst == IDX_W'(r));
        assign decVec[r] = wb_valid && (wb_dst == IDX_W'(r));

        reg_busy_counter u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (flush),
            .inc     (incVec[r]),
            .dec     (decVec[r]),
            .count   (countArr[r]),
            .busy    (busyVec[r]),
            .sat     (satVec[r])
        );
    end

    // Hazards see only current counts: a writeback frees its register next cycle.
    assign hazA      = iss_src_a_vld && busyVec[iss_src_a];
    assign hazB      = iss_src_b_vld && busyVec[iss_src_b];
    assign fullD     = iss_dst_vld && satVec[iss_dst];
    assign iss_ready = !flush && !hazA && !hazB && !fullD;
    assign fire      = iss_valid && iss_ready;

    assign busy_mask = busyVec;

    // Net change of the total is the accepted issue minus the effective retire.
    assign incOne     = fire && iss_dst_vld;
    assign decOne     = wb_valid && (countArr[wb_dst] != '0);
    assign wbSpurious = wb_valid && !flush && (countArr[wb_dst] == '0)
                        && !(incOne && (iss_dst == wb_dst));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight  <= '0;
            stall_cnt <= '0;
            wb_err    <= 1'b0;
        end else begin
            if (flush) begin
                inflight <= '0;
            end else begin
                inflight <= inflight + INFL_W'(incOne) - INFL_W'(decOne);
            end
            if (iss_valid && !iss_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (wbSpurious) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: inputs change on the falling edge,
// registered outputs are sampled on the falling edge after the rising edge.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic             clk;
    logic             reset_n;
    logic             iss_valid;
    logic             iss_ready;
    logic             iss_src_a_vld;
    reg_idx_t         iss_src_a;
    logic             iss_src_b_vld;
    reg_idx_t         iss_src_b;
    logic             iss_dst_vld;
    reg_idx_t         iss_dst;
    logic             wb_valid;
    reg_idx_t         wb_dst;
    logic             flush;
    logic [NREGS-1:0] busy_mask;
    logic [INFL_W-1:0] inflight;
    logic [STALL_W-1:0] stall_cnt;
    logic             wb_err;

    int nChecks = 0;
    int nFails  = 0;

    regfile_scoreboard dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_src_a_vld (iss_src_a_vld),
        .iss_src_a     (iss_src_a),
        .iss_src_b_vld (iss_src_b_vld),
        .iss_src_b     (iss_src_b),
        .iss_dst_vld   (iss_dst_vld),
        .iss_dst       (iss_dst),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .inflight      (inflight),
        .stall_cnt     (stall_cnt),
        .wb_err        (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idleInputs();
        iss_valid     = 1'b0;
        iss_src_a_vld = 1'b0;
        iss_src_a     = '0;
        iss_src_b_vld = 1'b0;
        iss_src_b     = '0;
        iss_dst_vld   = 1'b0;
        iss_dst       = '0;
        wb_valid      = 1'b0;
        wb_dst        = '0;
        flush         = 1'b0;
    endtask

    task automatic issueDst(input reg_idx_t d);
        iss_valid   = 1'b1;
        iss_dst_vld = 1'b1;
        iss_dst     = d;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        reset_n = 1'b0;
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        #1;
        checkVal("rst_busy", 32'(busy_mask), 32'h0);
        checkVal("rst_inflight", 32'(inflight), 32'h0);
        checkVal("rst_stall", stall_cnt, 32'h0);
        checkVal("rst_wberr", 32'(wb_err), 32'h0);
        checkVal("rst_ready", 32'(iss_ready), 32'h1);

        // Issue to RAX with no sources.
        nextCycle();
        issueDst(REG_RAX);
        #1 checkVal("t1_ready", 32'(iss_ready), 32'h1);
        nextCycle();
        idleInputs();
        checkVal("t1_busy", 32'(busy_mask), 32'h0001);
        checkVal("t1_inflight", 32'(inflight), 32'h1);

        // RAW stall on RAX, held three cycles, then writeback without bypass.
        iss_valid     = 1'b1;
        iss_src_a_vld = 1'b1;
        iss_src_a     = REG_RAX;
        #1 checkVal("t2_ready_haz", 32'(iss_ready), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            checkVal("t2_stall_inc", stall_cnt, 32'(i));
        end
        wb_valid = 1'b1;
        wb_dst   = REG_RAX;
        #1 checkVal("t2_no_bypass", 32'(iss_ready), 32'h0);
        nextCycle();
        wb_valid = 1'b0;
        #1;
        checkVal("t2_ready_after_wb", 32'(iss_ready), 32'h1);
        checkVal("t2_busy_after_wb", 32'(busy_mask), 32'h0);
        checkVal("t2_inflight_after_wb", 32'(inflight), 32'h0);
        checkVal("t2_stall", stall_cnt, 32'd4);
        nextCycle();
        idleInputs();

        // Saturation on RBP: three accepted, fourth blocked.
        issueDst(REG_RBP);
        for (int i = 0; i < 3; i++) begin
            #1 checkVal("t3_ready_fill", 32'(iss_ready), 32'h1);
            nextCycle();
        end
        checkVal("t3_inflight3", 32'(inflight), 32'd3);
        checkVal("t3_busy", 32'(busy_mask), 32'h0020);
        #1 checkVal("t3_ready_full", 32'(iss_ready), 32'h0);
        nextCycle();
        wb_valid = 1'b1;
        wb_dst   = REG_RBP;
        #1 checkVal("t3_ready_full_wb", 32'(iss_ready), 32'h0);
        nextCycle();
        wb_valid = 1'b0;
        #1 checkVal("t3_ready_after_wb", 32'(iss_ready), 32'h1);
        nextCycle();
        idleInputs();
        checkVal("t3_inflight_refill", 32'(inflight), 32'd3);
        checkVal("t3_stall", stall_cnt, 32'd6);

        // Simultaneous issue and writeback on RBX with count 1.
        issueDst(REG_RBX);
        nextCycle();
        checkVal("t4_inflight_pre", 32'(inflight), 32'd4);
        wb_valid = 1'b1;
        wb_dst   = REG_RBX;
        #1 checkVal("t4_ready", 32'(iss_ready), 32'h1);
        nextCycle();
        idleInputs();
        checkVal("t4_inflight", 32'(inflight), 32'd4);
        checkVal("t4_busy", 32'(busy_mask), 32'h0028);
        checkVal("t4_wberr", 32'(wb_err), 32'h0);

        // Clear, then build 7 pending writes over RCX/RSI/R12 and flush.
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        checkVal("t5_preflush_inflight", 32'(inflight), 32'h0);
        begin
            reg_idx_t seq [7];
            seq = '{REG_RCX, REG_RCX, REG_RCX, REG_RSI, REG_RSI, REG_R12, REG_R12};
            for (int i = 0; i < 7; i++) begin
                issueDst(seq[i]);
                nextCycle();
            end
        end
        idleInputs();
        checkVal("t5_inflight7", 32'(inflight), 32'd7);
        checkVal("t5_busy7", 32'(busy_mask), 32'h1042);
        flush = 1'b1;
        issueDst(REG_RDX);
        wb_valid = 1'b1;
        wb_dst   = REG_R15;
        #1 checkVal("t5_ready_flush", 32'(iss_ready), 32'h0);
        nextCycle();
        idleInputs();
        checkVal("t5_busy_flush", 32'(busy_mask), 32'h0);
        checkVal("t5_inflight_flush", 32'(inflight), 32'h0);
        checkVal("t5_wberr_flush", 32'(wb_err), 32'h0);
        checkVal("t5_stall", stall_cnt, 32'd7);

        // Spurious writeback sets a sticky error.
        wb_valid = 1'b1;
        wb_dst   = REG_R15;
        nextCycle();
        idleInputs();
        checkVal("t6_wberr_set", 32'(wb_err), 32'h1);
        checkVal("t6_inflight", 32'(inflight), 32'h0);
        issueDst(REG_RDI);
        nextCycle();
        idleInputs();
        nextCycle();
        checkVal("t6_wberr_sticky", 32'(wb_err), 32'h1);
        checkVal("t6_busy_rdi", 32'(busy_mask), 32'h0080);

        // Mid-cycle asynchronous reset.
        #2 reset_n = 1'b0;
        #1;
        checkVal("t6_arst_busy", 32'(busy_mask), 32'h0);
        checkVal("t6_arst_inflight", 32'(inflight), 32'h0);
        checkVal("t6_arst_stall", stall_cnt, 32'h0);
        checkVal("t6_arst_wberr", 32'(wb_err), 32'h0);
        checkVal("t6_arst_ready", 32'(iss_ready), 32'h1);
        nextCycle();
        reset_n = 1'b1;

        // Same register as source and destination while idle.
        issueDst(REG_RSP);
        iss_src_a_vld = 1'b1;
        iss_src_a     = REG_RSP;
        #1 checkVal("t7_srcdst_ready", 32'(iss_ready), 32'h1);
        nextCycle();
        idleInputs();
        checkVal("t7_busy", 32'(busy_mask), 32'h0010);
        checkVal("t7_inflight", 32'(inflight), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks outstanding writes to the 16 architectural integer registers (encoding 0=RAX, 1=RCX, 2=RDX, 3=RBX, 4=RSP, 5=RBP, 6=RSI, 7=RDI, 8..15=R8..R15).
- Sits between decode/issue and the register file.
- Gates issue on read-after-write hazards and on saturation of in-flight writes per destination.
- Retires pending writes on writeback and clears everything on pipeline flush.

Parameters:
- NREGS, 16, number of architectural registers tracked.
- IDX_W, 4, register index width (log2 NREGS).
- CNT_W, 2, per-register in-flight write counter width; max outstanding writes per register = 2^CNT_W-1 = 3.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- iss_valid  in  1  issue request present.
- iss_ready  out  1  scoreboard accepts issue this cycle (combinational).
- iss_src_a_vld  in  1  source A is used.
- iss_src_a  in  IDX_W  source A index.
- iss_src_b_vld  in  1  source B is used.
- iss_src_b  in  IDX_W  source B index.
- iss_dst_vld  in  1  instruction writes a register.
- iss_dst  in  IDX_W  destination index.
- wb_valid  in  1  writeback completing this cycle.
- wb_dst  in  IDX_W  register being written back.
- flush  in  1  discard all in-flight writes.
- busy_mask  out  NREGS  bit r = 1 when count[r] != 0 (registered).
- inflight  out  6  total pending writes across all registers (registered).
- stall_cnt  out  32  cycles with iss_valid && !iss_ready, saturating.
- wb_err  out  1  sticky: writeback to a register with count 0.

Behaviour:
- Reset (async, reset_n=0): all count[r]=0, busy_mask=0, inflight=0, stall_cnt=0, wb_err=0. iss_ready evaluates from the zeroed state, so it is 1 whenever flush=0.
- Hazard (combinational):
  - haz_a = iss_src_a_vld && count[iss_src_a]!=0; haz_b likewise.
  - full_d = iss_dst_vld && count[iss_dst]==max.
- iss_ready = !flush && !haz_a && !haz_b && !full_d. Independent of iss_valid.
- fire = iss_valid && iss_ready. No same-cycle bypass: a wb_valid in cycle N does not unblock a source until cycle N+1.
- Per-register update at posedge, priority order:
  1. flush=1: count[r] <= 0 for all r; same-cycle fire is impossible and wb is ignored (no wb_err).
  2. inc = fire && iss_dst_vld && iss_dst==r; dec = wb_valid && wb_dst==r && count[r]!=0.
     - inc && dec: unchanged.
     - inc only: +1.
     - dec only: -1.
- wb_valid with count[wb_dst]==0 (and no same-cycle inc to that register, no flush): count is unchanged and wb_err <= 1 (sticky until reset).
- inflight: next value = sum of next counts. Max 16*3=48 fits 6 bits. Flush gives 0 next cycle.
- stall_cnt: +1 per cycle with iss_valid && !iss_ready, including flush cycles. Holds at 0xFFFF_FFFF.
- WAW: issue with a busy destination is allowed until the count saturates. Writebacks are in-order per register; the scoreboard does not match tags.
- Same register as src and dst with count 0: issues; count becomes 1.
- Latency: 1 cycle from issue/wb/flush to the busy_mask/inflight/iss_ready effect.

Decomposition:
- Package regfile_pkg:
  - NREGS, IDX_W.
  - typedef reg_idx_t (logic[IDX_W-1:0]).
  - named register constants REG_RAX..REG_R15 matching the encoding above.
  - shared with RegFile and decode.
- Sub-module reg_busy_counter, instantiated NREGS times.
  - Inputs: clk, reset_n, clr, inc, dec.
  - Outputs: count, busy, sat.
  - Implements the priority rules above. Top level holds the hazard logic, inflight adder tree, stall counter and wb_err.

Test Plan:
1. Reset then issue dst=0 (RAX), no sources -> iss_ready=1; next cycle busy_mask=0x0001, inflight=1.
2. RAW stall:
   - With RAX busy, issue src_a=0 -> iss_ready=0 and stall_cnt increments each cycle.
   - wb_valid wb_dst=0 at cycle N -> busy_mask=0 and iss_ready=1 at N+1; no bypass at N.
3. Saturation: three issues dst=5 (RBP) -> count=3; fourth issue dst=5 -> iss_ready=0. One wb to 5 -> accepted next cycle.
4. Simultaneous issue dst=3 and wb dst=3 with count[3]=1 -> count stays 1, inflight unchanged, busy_mask bit3=1.
5. Flush with inflight=7 across RCX/RSI/R12 -> next cycle busy_mask=0, inflight=0. iss_ready=0 during the flush cycle; a wb in the same cycle is ignored and wb_err stays 0.
6. Spurious wb to R15 with count 0 -> wb_err=1 and stays 1. reset_n pulsed low mid-run -> all outputs 0 immediately, asynchronously.
